// File: rtl/ahb_cmd_pkg.sv
// ahb_cmd_pkg: command encodings for the AHB master port and the arbiter state type
package ahb_cmd_pkg;
  typedef enum logic [1:0] {CMD_IDLE = 2'b00, CMD_READ = 2'b01, CMD_WRITE = 2'b10} cmd_e;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_e;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request at or above ptr, wrapping modulo NREQ
//   req    request vector
//   ptr    search start index
//   found  any request set
//   idx    index of the winner
module rr_priority_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IW = $clog2(NREQ);
  int j;
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      j = j >= NREQ ? j - NREQ : j;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/ahb_cmd_arbiter.sv
// ahb_cmd_arbiter: round-robin sharing of one AHB master command port among NREQ byte requesters
//   HCLK, HRESET                          clock, synchronous active-high reset
//   req_valid/write/addr/wdata, req_ready per-requester request in, acceptance pulse out
//   rsp_valid, rsp_rdata, rsp_err         per-requester completion pulse, read byte, timeout flag
//   instruction, addr_r, addr_w, data_w   command to the master
//   data_r, busy                          read byte and transfer-in-progress from the master
module ahb_cmd_arbiter
  import ahb_cmd_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        instruction,
  output logic [7:0]        addr_r,
  output logic [7:0]        addr_w,
  output logic [7:0]        data_w,
  input  logic [7:0]        data_r,
  input  logic              busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  arb_state_e state, state_n;
  cmd_e ins, ins_n;
  logic [IW-1:0] g, g_n, rr, rr_n, pick;
  logic found, wr, wr_n, err_n, sel_wr;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] addr_r_n, addr_w_n, data_w_n, rdata_n, sel_addr, sel_data;
  logic [NREQ-1:0] ready_n, valid_n;
  rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .req(req_valid),
    .ptr(rr),
    .found(found),
    .idx(pick)
  );
  assign instruction = ins;
  assign sel_wr = req_write[pick];
  assign sel_addr = req_addr[{pick, 3'b000} +: 8];
  assign sel_data = req_wdata[{pick, 3'b000} +: 8];
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ARB_IDLE;
      ins <= CMD_IDLE;
      g <= '0;
      rr <= '0;
      wr <= 1'b0;
      cnt <= '0;
      addr_r <= '0;
      addr_w <= '0;
      data_w <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      ins <= ins_n;
      g <= g_n;
      rr <= rr_n;
      wr <= wr_n;
      cnt <= cnt_n;
      addr_r <= addr_r_n;
      addr_w <= addr_w_n;
      data_w <= data_w_n;
      req_ready <= ready_n;
      rsp_valid <= valid_n;
      rsp_rdata <= rdata_n;
      rsp_err <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    ins_n = ins;
    g_n = g;
    rr_n = rr;
    wr_n = wr;
    cnt_n = cnt;
    addr_r_n = addr_r;
    addr_w_n = addr_w;
    data_w_n = data_w;
    ready_n = '0;
    valid_n = '0;
    rdata_n = rsp_rdata;
    err_n = rsp_err;
    case (state)
      ARB_IDLE: if (found) begin
        state_n = ARB_ISSUE;
        g_n = pick;
        wr_n = sel_wr;
        cnt_n = '0;
        ready_n = NREQ'(1) << pick;
        ins_n = sel_wr ? CMD_WRITE : CMD_READ;
        addr_r_n = sel_wr ? 8'h00 : sel_addr;
        addr_w_n = sel_wr ? sel_addr : 8'h00;
        data_w_n = sel_wr ? sel_data : 8'h00;
      end
      ARB_ISSUE: if (busy) begin
        state_n = ARB_WAIT;
        ins_n = CMD_IDLE;
      end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
        // the master never acknowledged: give up and report the error to the winner
        state_n = ARB_IDLE;
        ins_n = CMD_IDLE;
        valid_n = NREQ'(1) << g;
        rdata_n = 8'h00;
        err_n = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      ARB_WAIT: if (!busy) begin
        state_n = ARB_IDLE;
        valid_n = NREQ'(1) << g;
        rdata_n = wr ? 8'h00 : data_r;
        err_n = 1'b0;
        rr_n = (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
      end
      default: state_n = ARB_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ahb_cmd_arbiter.sv
// tb_ahb_cmd_arbiter: directed checks of the arbiter with NREQ=2 and NREQ=3 instances
module tb_ahb_cmd_arbiter;
  logic clk = 1'b0, rst = 1'b1, hang = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid, instruction;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [7:0] rsp_rdata, addr_r, addr_w, data_w, data_r = 8'h00;
  logic rsp_err, busy = 1'b0;
  int ph = 0;
  logic [2:0] v3 = '0, w3 = '0, rdy3, rv3;
  logic [23:0] a3 = '0, d3 = '0;
  logic [7:0] rd3, ar3, aw3, dw3, dr3 = 8'h00;
  logic [1:0] ins3;
  logic err3, busy3 = 1'b0;
  int ph3 = 0;
  int n_chk = 0, n_err = 0;
  ahb_cmd_arbiter #(.NREQ(2), .ACK_TIMEOUT(16)) dut (
    .HCLK(clk), .HRESET(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .instruction(instruction), .addr_r(addr_r), .addr_w(addr_w),
    .data_w(data_w), .data_r(data_r), .busy(busy)
  );
  ahb_cmd_arbiter #(.NREQ(3), .ACK_TIMEOUT(16)) dut3 (
    .HCLK(clk), .HRESET(rst), .req_valid(v3), .req_write(w3), .req_addr(a3),
    .req_wdata(d3), .req_ready(rdy3), .rsp_valid(rv3), .rsp_rdata(rd3),
    .rsp_err(err3), .instruction(ins3), .addr_r(ar3), .addr_w(aw3),
    .data_w(dw3), .data_r(dr3), .busy(busy3)
  );
  // master model: busy rises one cycle after a command appears, stays high two cycles
  always @(posedge clk) begin
    if (rst || hang) begin
      busy <= 1'b0;
      ph <= 0;
    end else if (ph == 0 && instruction != 2'b00) begin
      busy <= 1'b1;
      ph <= 1;
      data_r <= addr_r ^ 8'h99;
    end else if (ph == 1) ph <= 2;
    else if (ph == 2) begin
      busy <= 1'b0;
      ph <= 0;
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      busy3 <= 1'b0;
      ph3 <= 0;
    end else if (ph3 == 0 && ins3 != 2'b00) begin
      busy3 <= 1'b1;
      ph3 <= 1;
      dr3 <= ar3 ^ 8'h99;
    end else if (ph3 == 1) ph3 <= 2;
    else if (ph3 == 2) begin
      busy3 <= 1'b0;
      ph3 <= 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_ready(input logic i, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[i] && n < 50);
    req_valid[i] = 1'b0;
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid == 2'b00 && n < 50);
  endtask
  task automatic do_req(input string tag, input logic i, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd, input logic exp_err,
                        input int exp_lat);
    int n;
    req_write[i] = w;
    req_addr[{i, 3'b000} +: 8] = a;
    req_wdata[{i, 3'b000} +: 8] = d;
    req_valid[i] = 1'b1;
    wait_ready(i, n);
    chk({tag, "_ready"}, req_ready, i ? 2'b10 : 2'b01);
    chk({tag, "_instr"}, instruction, w ? 2'b10 : 2'b01);
    chk({tag, "_addr_r"}, addr_r, w ? 8'h00 : a);
    chk({tag, "_addr_w"}, addr_w, w ? a : 8'h00);
    chk({tag, "_data_w"}, data_w, w ? d : 8'h00);
    wait_rsp(n);
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_rsp_valid"}, rsp_valid, i ? 2'b10 : 2'b01);
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, rsp_err, exp_err);
    chk({tag, "_instr_idle"}, instruction, 2'b00);
  endtask
  initial begin
    int n, c0, c1;
    int order[$];
    logic [1:0] seen;
    req_valid = 2'b11;
    req_addr = {8'h51, 8'h50};
    repeat (3) @(negedge clk);
    chk("rst_instr", instruction, 2'b00);
    chk("rst_addr_r", addr_r, 8'h00);
    chk("rst_addr_w", addr_w, 8'h00);
    chk("rst_data_w", data_w, 8'h00);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_err", rsp_err, 1'b0);
    rst = 1'b0;
    c0 = 0;
    c1 = 0;
    for (int c = 0; c < 200 && order.size() < 8; c++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        order.push_back(0);
        c0++;
        if (c0 == 4) req_valid[0] = 1'b0;
      end
      if (req_ready[1]) begin
        order.push_back(1);
        c1++;
        if (c1 == 4) req_valid[1] = 1'b0;
      end
    end
    chk("cont_grants", order.size(), 8);
    for (int k = 0; k < order.size(); k++) chk($sformatf("cont_grant%0d", k), order[k], k % 2);
    wait_rsp(n);
    chk("cont_last_rsp", rsp_valid, 2'b10);
    do_req("read", 1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 4);
    do_req("write", 1'b1, 1'b1, 8'h10, 8'h7E, 8'h00, 1'b0, 4);
    hang = 1'b1;
    do_req("timeout", 1'b0, 1'b0, 8'h22, 8'h00, 8'h00, 1'b1, 16);
    hang = 1'b0;
    do_req("after_to", 1'b1, 1'b1, 8'h33, 8'h44, 8'h00, 1'b0, 4);
    do_req("pre_rst", 1'b0, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0, 4);
    req_write[1] = 1'b0;
    req_addr[15:8] = 8'h40;
    req_valid[1] = 1'b1;
    wait_ready(1'b1, n);
    chk("mid_ready", req_ready, 2'b10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_instr", instruction, 2'b00);
    chk("mid_rst_valid", rsp_valid, 2'b00);
    seen = '0;
    repeat (8) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    chk("mid_rst_no_rsp", seen, 2'b00);
    req_write = 2'b00;
    req_addr = {8'h41, 8'h40};
    req_valid = 2'b11;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == 2'b00 && n < 50);
    chk("post_rst_first", req_ready, 2'b01);
    req_valid[0] = 1'b0;
    wait_rsp(n);
    chk("post_rst_rsp0", rsp_valid, 2'b01);
    wait_ready(1'b1, n);
    chk("post_rst_second", req_ready, 2'b10);
    wait_rsp(n);
    chk("post_rst_rsp1", rsp_valid, 2'b10);
    chk("post_rst_rdata1", rsp_rdata, 8'hD8);
    a3[15:8] = 8'h61;
    v3 = 3'b010;
    n = 0;
    do begin @(negedge clk); n++; end while (rdy3 == 3'b000 && n < 50);
    v3 = 3'b000;
    chk("n3_first_ready", rdy3, 3'b010);
    n = 0;
    do begin @(negedge clk); n++; end while (rv3 == 3'b000 && n < 50);
    chk("n3_first_rsp", rv3, 3'b010);
    chk("n3_first_rdata", rd3, 8'hF8);
    order.delete();
    c0 = 0;
    c1 = 0;
    v3 = 3'b101;
    for (int c = 0; c < 200 && order.size() < 4; c++) begin
      @(negedge clk);
      if (rdy3[0]) begin
        order.push_back(0);
        c0++;
        if (c0 == 2) v3[0] = 1'b0;
      end
      if (rdy3[2]) begin
        order.push_back(2);
        c1++;
        if (c1 == 2) v3[2] = 1'b0;
      end
      chk($sformatf("n3_no_req1_c%0d", c), rdy3[1], 1'b0);
    end
    chk("n3_grants", order.size(), 4);
    for (int k = 0; k < order.size(); k++) chk($sformatf("n3_grant%0d", k), order[k], (k % 2 == 0) ? 2 : 0);
    n = 0;
    do begin @(negedge clk); n++; end while (rv3 == 3'b000 && n < 50);
    chk("n3_last_rsp", rv3, 3'b001);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
